dmem_arbiter: RTL and testbench

Shares the single-port data memory between the `cmp` core's data port and the node's network interface (NIC). Core accesses are single-beat; NIC accesses are fixed-length bursts of up to `MAX_BURST` words. Core requests and write data pass through combinationally when granted. A registered FSM sequences NIC bursts and alternates priority between the two requesters. The block sits between `cmp` (memEn/memWrEn/addr_out/d_out/d_in) and the data memory.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arb_if.sv | 54 +++++
 rtl/dmem_arbiter_nic_burst_ctr.sv | 44 ++++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DATA_W_DEF    = 64;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    NIC_GRANT = 2'd1,
    NIC_BURST = 2'd2
  } state_e;

  // Which requester owns the read data returning this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_NIC  = 2'd2
  } owner_e;

  function automatic int unsigned len_w(input int unsigned max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Core, NIC and memory-port signals of the data-memory arbiter.
interface dmem_arb_if #(
  parameter int unsigned ADDR_W    = dmem_arb_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W    = dmem_arb_pkg::DATA_W_DEF,
  parameter int unsigned MAX_BURST = dmem_arb_pkg::MAX_BURST_DEF
);
  import dmem_arb_pkg::*;

  localparam int unsigned LEN_W = len_w(MAX_BURST);

  logic              core_memEn;
  logic              core_memWrEn;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_wait;

  logic              nic_req;
  logic              nic_wr;
  logic [ADDR_W-1:0] nic_addr;
  logic [LEN_W-1:0]  nic_len;
  logic [DATA_W-1:0] nic_wdata;
  logic              nic_beat;
  logic [DATA_W-1:0] nic_rdata;
  logic              nic_rvalid;
  logic              nic_done;

  logic              mem_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  core_memEn, core_memWrEn, core_addr, core_wdata,
    output core_rdata, core_wait,
    input  nic_req, nic_wr, nic_addr, nic_len, nic_wdata,
    output nic_beat, nic_rdata, nic_rvalid, nic_done,
    output mem_en, mem_wr_en, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment side: requesters and memory
  modport master (
    output core_memEn, core_memWrEn, core_addr, core_wdata,
    input  core_rdata, core_wait,
    output nic_req, nic_wr, nic_addr, nic_len, nic_wdata,
    input  nic_beat, nic_rdata, nic_rvalid, nic_done,
    input  mem_en, mem_wr_en, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_nic_burst_ctr.sv
// NIC burst sequencer: latched base/len/dir, beat counter, wrapped beat address.
module nic_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  input  logic              wr,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] beat_addr_c,
  output logic              last_beat_c,
  output logic              wr_q
);

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
      wr_q   <= 1'b0;
    end else if (load) begin
      base_q <= base;
      len_q  <= len;
      beat_q <= '0;
      wr_q   <= wr;
    end else if (adv) begin
      beat_q <= beat_q + LEN_W'(1);
    end
  end

  // Address wraps naturally at ADDR_W bits
  assign beat_addr_c = base_q + ADDR_W'(beat_q);
  assign last_beat_c = (beat_q == len_q);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (single beats) and NIC bursts.
// Define DMEM_ARB_RR_EN for alternating core/NIC priority; otherwise the core always wins.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       reset,
  dmem_arb_if.slave  bus
);

  localparam int unsigned LEN_W = len_w(MAX_BURST);

  state_e state_q, state_d;
  owner_e rd_owner_q, rd_owner_d;
  logic   rd_last_q, rd_last_d;
`ifdef DMEM_ARB_RR_EN
  logic   pri_q, pri_d;
`endif

  logic              core_grant_c;
  logic              ctr_load_c;
  logic              beat_c;
  logic              mem_en_c;
  logic              mem_wr_en_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [ADDR_W-1:0] beat_addr_c;
  logic              last_beat_c;
  logic              burst_wr_q;

  nic_burst_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_ctr (
    .clk         (clk),
    .rst_n       (reset),
    .load        (ctr_load_c),
    .adv         (beat_c),
    .wr          (bus.nic_wr),
    .base        (bus.nic_addr),
    .len         (bus.nic_len),
    .beat_addr_c (beat_addr_c),
    .last_beat_c (last_beat_c),
    .wr_q        (burst_wr_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_owner_q <= OWN_NONE;
      rd_last_q  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      pri_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      rd_last_q  <= rd_last_d;
`ifdef DMEM_ARB_RR_EN
      pri_q      <= pri_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_owner_d   = OWN_NONE;
    rd_last_d    = 1'b0;
    core_grant_c = 1'b0;
    ctr_load_c   = 1'b0;
    beat_c       = 1'b0;
    mem_en_c     = 1'b0;
    mem_wr_en_c  = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
`ifdef DMEM_ARB_RR_EN
    pri_d        = pri_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Grant is gated by reset so the memory port stays quiet while held
`ifdef DMEM_ARB_RR_EN
        core_grant_c = reset & bus.core_memEn & ~(bus.nic_req & pri_q);
`else
        core_grant_c = reset & bus.core_memEn;
`endif
        if (core_grant_c) begin
          mem_en_c    = 1'b1;
          mem_wr_en_c = bus.core_memWrEn;
          mem_addr_c  = bus.core_addr;
          mem_wdata_c = bus.core_wdata;
          rd_owner_d  = bus.core_memWrEn ? OWN_NONE : OWN_CORE;
`ifdef DMEM_ARB_RR_EN
          pri_d       = 1'b1;
`endif
        end else if (bus.nic_req) begin
          state_d = NIC_GRANT;
        end
      end
      NIC_GRANT: begin
        ctr_load_c = 1'b1;
        state_d    = NIC_BURST;
      end
      NIC_BURST: begin
        beat_c      = 1'b1;
        mem_en_c    = 1'b1;
        mem_wr_en_c = burst_wr_q;
        mem_addr_c  = beat_addr_c;
        mem_wdata_c = bus.nic_wdata;
        if (!burst_wr_q) begin
          rd_owner_d = OWN_NIC;
          rd_last_d  = last_beat_c;
        end
        if (last_beat_c) begin
          state_d = IDLE;
`ifdef DMEM_ARB_RR_EN
          pri_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_en     = mem_en_c;
  assign bus.mem_wr_en  = mem_wr_en_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.core_wait  = bus.core_memEn & ~core_grant_c;
  assign bus.nic_beat   = beat_c;

  // Read data is steered by who issued the read one cycle earlier
  assign bus.core_rdata = (rd_owner_q == OWN_CORE) ? bus.mem_rdata : '0;
  assign bus.nic_rdata  = (rd_owner_q == OWN_NIC)  ? bus.mem_rdata : '0;
  assign bus.nic_rvalid = (rd_owner_q == OWN_NIC);
  assign bus.nic_done   = (beat_c & burst_wr_q & last_beat_c) | rd_last_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus reset/priority sequences.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wd;
    logic        nreq;
    logic        nwr;
    logic [31:0] naddr;
    logic [1:0]  nlen;
    logic [63:0] nwd;
  } in_t;

  typedef struct packed {
    logic        cwait;
    logic [63:0] crd;
    logic        men;
    logic        mwe;
    logic [31:0] maddr;
    logic [63:0] mwd;
    logic        beat;
    logic        rvalid;
    logic [63:0] nrd;
    logic        done;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  localparam logic        H  = 1'b1;
  localparam logic        L  = 1'b0;
  localparam logic [31:0] A0 = 32'h0;
  localparam logic [63:0] Z  = 64'h0;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t tbl[$];

  dmem_arb_if #(.ADDR_W(32), .DATA_W(64), .MAX_BURST(4)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(64), .MAX_BURST(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rd(input int idx);
    return 64'hD000_0000_0000_0000 | 64'(idx);
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic apply(input in_t v, input int idx);
    bus.core_memEn   = v.en;
    bus.core_memWrEn = v.we;
    bus.core_addr    = v.addr;
    bus.core_wdata   = v.wd;
    bus.nic_req      = v.nreq;
    bus.nic_wr       = v.nwr;
    bus.nic_addr     = v.naddr;
    bus.nic_len      = v.nlen;
    bus.nic_wdata    = v.nwd;
    bus.mem_rdata    = rd(idx);
  endtask

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic compare(input int idx, input out_t e);
    chk("core_wait",  idx, 64'(bus.core_wait),  64'(e.cwait));
    chk("core_rdata", idx, bus.core_rdata,      e.crd);
    chk("mem_en",     idx, 64'(bus.mem_en),     64'(e.men));
    chk("mem_wr_en",  idx, 64'(bus.mem_wr_en),  64'(e.mwe));
    chk("mem_addr",   idx, 64'(bus.mem_addr),   64'(e.maddr));
    chk("mem_wdata",  idx, bus.mem_wdata,       e.mwd);
    chk("nic_beat",   idx, 64'(bus.nic_beat),   64'(e.beat));
    chk("nic_rvalid", idx, 64'(bus.nic_rvalid), 64'(e.rvalid));
    chk("nic_rdata",  idx, bus.nic_rdata,       e.nrd);
    chk("nic_done",   idx, 64'(bus.nic_done),   64'(e.done));
  endtask

  initial begin
    in_t  zi;
    in_t  v;
    out_t zo;
    logic [9:0] rr_wait;
    logic [9:0] rr_beat;
    checks = 0;
    errors = 0;
    zi = '0;
    zo = '0;

    // Cycle-by-cycle table: every row is one clock after reset release
    add('{H,L,32'h10,64'h1111,L,L,A0,2'd0,Z}, '{L,Z,H,L,32'h10,64'h1111,L,L,Z,L});            // 0 core read
    add(zi, '{L,rd(1),L,L,A0,Z,L,L,Z,L});                                                       // 1 core rdata
    add('{H,H,32'h20,64'hCAFE,L,L,A0,2'd0,Z}, '{L,Z,H,H,32'h20,64'hCAFE,L,L,Z,L});             // 2 core write
    add(zi, zo);                                                                               // 3
    add('{L,L,A0,Z,H,H,32'h100,2'd3,64'h5000}, zo);                                            // 4 NIC wr T
    add('{L,L,A0,Z,H,H,32'h100,2'd3,64'h5000}, zo);                                            // 5 NIC_GRANT
    add('{L,L,A0,Z,H,H,32'h100,2'd3,64'h5000}, '{L,Z,H,H,32'h100,64'h5000,H,L,Z,L});           // 6 beat0
    add('{L,L,A0,Z,H,H,32'h100,2'd3,64'h5001}, '{L,Z,H,H,32'h101,64'h5001,H,L,Z,L});           // 7
    add('{L,L,A0,Z,H,H,32'h100,2'd3,64'h5002}, '{L,Z,H,H,32'h102,64'h5002,H,L,Z,L});           // 8
    add('{L,L,A0,Z,H,H,32'h100,2'd3,64'h5003}, '{L,Z,H,H,32'h103,64'h5003,H,L,Z,H});           // 9 last, done
    add('{H,L,32'h30,Z,L,L,A0,2'd0,Z}, '{L,Z,H,L,32'h30,Z,L,L,Z,L});                          // 10 core after burst
    add(zi, '{L,rd(11),L,L,A0,Z,L,L,Z,L});                                                      // 11
    add('{L,L,A0,Z,H,L,32'h200,2'd1,Z}, zo);                                                   // 12 NIC rd T
    add('{H,L,32'h44,Z,H,L,32'h200,2'd1,Z}, '{H,Z,L,L,A0,Z,L,L,Z,L});                         // 13 grant, core waits
    add('{H,L,32'h44,Z,H,L,32'h200,2'd1,Z}, '{H,Z,H,L,32'h200,Z,H,L,Z,L});                    // 14 beat0
    add('{H,L,32'h44,Z,H,L,32'h200,2'd1,Z}, '{H,Z,H,L,32'h201,Z,H,H,rd(15),L});               // 15 beat1
    add('{H,L,32'h44,Z,L,L,A0,2'd0,Z}, '{L,Z,H,L,32'h44,Z,L,H,rd(16),H});                     // 16 core wins, done
    add(zi, '{L,rd(17),L,L,A0,Z,L,L,Z,L});                                                      // 17
    add('{L,L,A0,Z,H,H,32'hFFFF_FFFE,2'd3,64'h9}, zo);                                         // 18 wrap T
    add('{L,L,A0,Z,H,H,32'hFFFF_FFFE,2'd3,64'h9}, zo);                                         // 19
    add('{L,L,A0,Z,H,H,32'hFFFF_FFFE,2'd3,64'h9}, '{L,Z,H,H,32'hFFFF_FFFE,64'h9,H,L,Z,L});    // 20
    add('{L,L,A0,Z,H,H,32'hFFFF_FFFE,2'd3,64'h9}, '{L,Z,H,H,32'hFFFF_FFFF,64'h9,H,L,Z,L});    // 21
    add('{L,L,A0,Z,H,H,32'hFFFF_FFFE,2'd3,64'h9}, '{L,Z,H,H,32'h0,64'h9,H,L,Z,L});            // 22
    add('{L,L,A0,Z,H,H,32'hFFFF_FFFE,2'd3,64'h9}, '{L,Z,H,H,32'h1,64'h9,H,L,Z,H});            // 23
    add(zi, zo);                                                                               // 24
`ifndef DMEM_ARB_RR_EN
    add('{H,L,32'h60,Z,H,L,32'h400,2'd1,Z}, '{L,Z,H,L,32'h60,Z,L,L,Z,L});                     // 25 both: core
    add('{H,L,32'h60,Z,H,L,32'h400,2'd1,Z}, '{L,rd(26),H,L,32'h60,Z,L,L,Z,L});                // 26
    add('{H,L,32'h60,Z,H,L,32'h400,2'd1,Z}, '{L,rd(27),H,L,32'h60,Z,L,L,Z,L});                // 27
    add(zi, '{L,rd(28),L,L,A0,Z,L,L,Z,L});                                                      // 28
`endif

    // Reset state
    reset = 1'b0;
    apply(zi, 0);
    repeat (2) @(posedge clk);
    #1;
    compare(-1, zo);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].i, i);
      @(negedge clk);
      compare(i, tbl[i].o);
      @(posedge clk);
      #1;
    end

    // Reset asserted during beat 1 of a 4-beat write burst
    v = '{L,L,A0,Z,H,H,32'h300,2'd3,64'h77};
    apply(v, 100);
    @(posedge clk); #1;
    apply(v, 101);
    @(posedge clk); #1;
    apply(v, 102);
    @(negedge clk);
    chk("abort_beat0_addr", 102, 64'(bus.mem_addr), 64'h300);
    @(posedge clk); #1;
    chk("abort_beat1_addr", 103, 64'(bus.mem_addr), 64'h301);
    reset = 1'b0;
    apply(zi, 103);
    #1;
    chk("abort_mem_en",   103, 64'(bus.mem_en),   64'h0);
    chk("abort_nic_beat", 103, 64'(bus.nic_beat), 64'h0);
    chk("abort_nic_done", 103, 64'(bus.nic_done), 64'h0);
    chk("abort_mem_addr", 103, 64'(bus.mem_addr), 64'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("abort_hold_done", 104 + c, 64'(bus.nic_done), 64'h0);
      chk("abort_hold_en",   104 + c, 64'(bus.mem_en),   64'h0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    apply('{H,L,32'h50,Z,L,L,A0,2'd0,Z}, 110);
    #1;
    chk("release_core_en",   110, 64'(bus.mem_en),    64'h1);
    chk("release_core_addr", 110, 64'(bus.mem_addr),  64'h50);
    chk("release_core_wait", 110, 64'(bus.core_wait), 64'h0);
    @(negedge clk);
    chk("release_nic_done",  110, 64'(bus.nic_done),  64'h0);
    @(posedge clk); #1;
    apply(zi, 111);
    @(negedge clk);
    chk("release_core_rdata", 111, bus.core_rdata,      rd(111));
    chk("release_nic_rvalid", 111, 64'(bus.nic_rvalid), 64'h0);
    chk("release_nic_done2",  111, 64'(bus.nic_done),   64'h0);
    @(posedge clk); #1;

`ifdef DMEM_ARB_RR_EN
    // Both requesting: pri is 1 after the core grant above, so the NIC goes first
    rr_wait = 10'b01_1110_1111;
    rr_beat = 10'b01_1000_1100;
    for (int c = 0; c < 10; c++) begin
      apply('{H,L,32'h60,Z,H,H,32'h400,2'd1,64'h42}, 120 + c);
      @(negedge clk);
      chk("rr_core_wait", c, 64'(bus.core_wait), 64'(rr_wait[c]));
      chk("rr_nic_beat",  c, 64'(bus.nic_beat),  64'(rr_beat[c]));
      chk("rr_mem_en",    c, 64'(bus.mem_en),    64'(rr_beat[c] | ~rr_wait[c]));
      @(posedge clk); #1;
    end
    apply(zi, 130);
    @(posedge clk); #1;
`else
    rr_wait = '0;
    rr_beat = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
